rs232_pixel_gatherer: RTL and testbench

Parametrised successor to the single-image UART loader. Polls an Avalon-MM UART and gathers IMAGE_NUMBER bytes per pixel, one from each exposure, interleaved pixel-major. It hands the byte vector to an external merge engine over a start/finish handshake, then writes the result to SRAM. Optionally echoes each result byte back over the UART TX register. Sits between the RS232 UART core and the SRAM writer / top wrapper.

---
 rtl/rs232_pixel_gatherer_if.sv | 30 +++
 rtl/rs232_pixel_gatherer.sv | 201 ++++++++++++++++++++
 tb/tb_rs232_pixel_gatherer.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_pixel_gatherer_if.sv
// UART register bus and merge-engine handshake seen by the pixel gatherer.
// The master side is the gatherer. The slave side is the UART core plus the merge engine.
interface rs232_pixel_gatherer_if #(
    parameter int IMAGE_NUMBER = 4
);
    logic [4:0]                avm_address;
    logic                      avm_read;
    logic                      avm_write;
    logic [31:0]               avm_writedata;
    logic [31:0]               avm_readdata;
    logic                      avm_waitrequest;
    logic                      calc_start;
    logic [IMAGE_NUMBER*8-1:0] calc_images;
    logic                      calc_finish;
    logic [7:0]                calc_result;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest,
        output calc_start, calc_images,
        input  calc_finish, calc_result
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest,
        input  calc_start, calc_images,
        output calc_finish, calc_result
    );
endinterface

// File: rtl/rs232_pixel_gatherer.sv
// Gathers IMAGE_NUMBER bytes per pixel from a polled UART.
// The bytes go to an external merge engine, and the merged byte is stored to SRAM.
// When TX_ECHO is set, each merged byte is also echoed back on UART TX.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_POLL_RX   | STATUS read in flight, waiting for RX ready (bit 7)
// S_READ_RX   | RX data read in flight, byte goes to slot byte_cnt
// S_WAIT_CALC | bus idle, calc_images held, waiting for calc_finish
// S_POLL_TX   | STATUS read in flight, waiting for TX ready (bit 6)
// S_WRITE_TX  | TX data write of the merged byte in flight
// S_NEXT      | decide between the next pixel and the end of the frame
// S_DONE      | frame complete, no bus traffic until reset
module rs232_pixel_gatherer #(
    parameter int IMAGE_NUMBER = 4,
    parameter int IMAGE_W      = 640,
    parameter int IMAGE_H      = 480,
    parameter int ADDR_W       = 20,
    parameter int TX_ECHO      = 1
) (
    input  logic                  avm_clk,
    input  logic                  avm_rst,
    rs232_pixel_gatherer_if.master bus,
    output logic [7:0]            pixel_value,
    output logic                  pixel_valid,
    output logic [ADDR_W-1:0]     addr_store,
    output logic                  store_finish
);
    localparam int NPIX  = IMAGE_W * IMAGE_H;
    localparam int PIX_W = $clog2(NPIX + 1);

    localparam logic [4:0] A_RX     = 5'd0;
    localparam logic [4:0] A_TX     = 5'd4;
    localparam logic [4:0] A_STATUS = 5'd8;

    typedef enum logic [2:0] {
        S_POLL_RX,
        S_READ_RX,
        S_WAIT_CALC,
        S_POLL_TX,
        S_WRITE_TX,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                byte_cnt_q, byte_cnt_d;
    logic [PIX_W-1:0]          pix_cnt_q, pix_cnt_d;
    logic                      read_q, read_d;
    logic                      write_q, write_d;
    logic [4:0]                address_q, address_d;
    logic [7:0]                tx_byte_q, tx_byte_d;
    logic                      calc_start_q, calc_start_d;
    logic [IMAGE_NUMBER*8-1:0] images_q, images_d;
    logic [7:0]                pixel_value_q, pixel_value_d;
    logic                      pixel_valid_q, pixel_valid_d;
    logic [ADDR_W-1:0]         addr_store_q, addr_store_d;
    logic                      store_finish_q, store_finish_d;

    logic xfer_done;
    logic unused_rdata;

    // A transfer completes on the first cycle its request sees waitrequest low.
    assign xfer_done    = (read_q | write_q) & ~bus.avm_waitrequest;
    assign unused_rdata = ^bus.avm_readdata[31:8];

    // Next-state logic and the next values of every registered output.
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        pix_cnt_d      = pix_cnt_q;
        read_d         = read_q;
        write_d        = write_q;
        address_d      = address_q;
        tx_byte_d      = tx_byte_q;
        calc_start_d   = 1'b0;
        images_d       = images_q;
        pixel_value_d  = pixel_value_q;
        pixel_valid_d  = 1'b0;
        addr_store_d   = addr_store_q;
        store_finish_d = store_finish_q;

        case (state_q)
            S_POLL_RX: begin
                // A not-ready status keeps read high, so the poll repeats with no idle cycle.
                if (xfer_done && bus.avm_readdata[7]) begin
                    address_d = A_RX;
                    state_d   = S_READ_RX;
                end
            end
            S_READ_RX: begin
                if (xfer_done) begin
                    for (int k = 0; k < IMAGE_NUMBER; k++) begin
                        if (byte_cnt_q == 4'(k)) begin
                            images_d[8*k +: 8] = bus.avm_readdata[7:0];
                        end
                    end
                    if (byte_cnt_q < 4'(IMAGE_NUMBER - 1)) begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        address_d  = A_STATUS;
                        state_d    = S_POLL_RX;
                    end else begin
                        byte_cnt_d   = 4'd0;
                        read_d       = 1'b0;
                        calc_start_d = 1'b1;
                        state_d      = S_WAIT_CALC;
                    end
                end
            end
            S_WAIT_CALC: begin
                if (bus.calc_finish) begin
                    pixel_value_d = bus.calc_result;
                    pixel_valid_d = 1'b1;
                    addr_store_d  = ADDR_W'(pix_cnt_q);
                    pix_cnt_d     = pix_cnt_q + 1'b1;
                    if (TX_ECHO != 0) begin
                        read_d    = 1'b1;
                        address_d = A_STATUS;
                        state_d   = S_POLL_TX;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_POLL_TX: begin
                if (xfer_done && bus.avm_readdata[6]) begin
                    read_d    = 1'b0;
                    write_d   = 1'b1;
                    address_d = A_TX;
                    tx_byte_d = pixel_value_q;
                    state_d   = S_WRITE_TX;
                end
            end
            S_WRITE_TX: begin
                if (xfer_done) begin
                    write_d = 1'b0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (pix_cnt_q == PIX_W'(NPIX)) begin
                    store_finish_d = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    read_d    = 1'b1;
                    address_d = A_STATUS;
                    state_d   = S_POLL_RX;
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_POLL_RX;
            end
        endcase
    end

    // State and output registers. The reset value starts the first STATUS poll.
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            state_q        <= S_POLL_RX;
            byte_cnt_q     <= '0;
            pix_cnt_q      <= '0;
            read_q         <= 1'b1;
            write_q        <= 1'b0;
            address_q      <= A_STATUS;
            tx_byte_q      <= '0;
            calc_start_q   <= 1'b0;
            images_q       <= '0;
            pixel_value_q  <= '0;
            pixel_valid_q  <= 1'b0;
            addr_store_q   <= '0;
            store_finish_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            read_q         <= read_d;
            write_q        <= write_d;
            address_q      <= address_d;
            tx_byte_q      <= tx_byte_d;
            calc_start_q   <= calc_start_d;
            images_q       <= images_d;
            pixel_value_q  <= pixel_value_d;
            pixel_valid_q  <= pixel_valid_d;
            addr_store_q   <= addr_store_d;
            store_finish_q <= store_finish_d;
        end
    end

    assign bus.avm_address   = address_q;
    assign bus.avm_read      = read_q;
    assign bus.avm_write     = write_q;
    assign bus.avm_writedata = {24'h0, tx_byte_q};
    assign bus.calc_start    = calc_start_q;
    assign bus.calc_images   = images_q;
    assign pixel_value       = pixel_value_q;
    assign pixel_valid       = pixel_valid_q;
    assign addr_store        = addr_store_q;
    assign store_finish      = store_finish_q;
endmodule

// File: tb/tb_rs232_pixel_gatherer.sv
// Bench for rs232_pixel_gatherer: UART slave model, merge-engine stimulus and pixel scoreboard.
`timescale 1ns/1ps
module tb_rs232_pixel_gatherer;
    localparam int IMAGE_NUMBER = 4;
    localparam int IMAGE_W      = 2;
    localparam int IMAGE_H      = 2;
    localparam int ADDR_W       = 4;
    localparam int TX_ECHO      = 1;
    localparam int NPIX         = IMAGE_W * IMAGE_H;

    typedef logic [7:0] img_t [IMAGE_NUMBER];
    typedef struct { int delay; logic [7:0] data; } rx_t;
    typedef struct { bit wr; logic [4:0] addr; logic [31:0] data; int cyc; } xfer_t;
    typedef struct { logic [7:0] v; logic [ADDR_W-1:0] a; int cyc; } pix_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        pixel_value;
    logic              pixel_valid;
    logic [ADDR_W-1:0] addr_store;
    logic              store_finish;

    rs232_pixel_gatherer_if #(.IMAGE_NUMBER(IMAGE_NUMBER)) bus();

    rs232_pixel_gatherer #(
        .IMAGE_NUMBER(IMAGE_NUMBER), .IMAGE_W(IMAGE_W), .IMAGE_H(IMAGE_H),
        .ADDR_W(ADDR_W), .TX_ECHO(TX_ECHO)
    ) dut (
        .avm_clk(clk), .avm_rst(rst_n), .bus(bus),
        .pixel_value(pixel_value), .pixel_valid(pixel_valid),
        .addr_store(addr_store), .store_finish(store_finish)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // UART model state
    rx_t   rx_q[$];
    xfer_t log_q[$];
    int    wait_cycles = 0, tx_busy_polls = 0, tx_left = 0, stall_cnt = 0;
    bit    tx_armed = 0;
    logic [38:0] held_req;
    int    stab_err = 0, both_err = 0, rx_early_err = 0, bad_addr_err = 0;

    // Monitor state
    int    cs_cnt = 0, cs_cyc = 0, sf_cyc = 0;
    logic [IMAGE_NUMBER*8-1:0] cs_images;
    pix_t  pix_log[$];
    bit    wait_window = 0, sf_prev = 0;
    int    wait_bus_err = 0, img_err = 0;
    int    exp_pix = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // UART slave: stalls each request wait_cycles times, then completes it.
    task automatic respond();
        logic [38:0] req;
        logic [31:0] rd;
        rx_t         h;
        bit          rx_rdy, tx_rdy;
        if (!rst_n) begin
            stall_cnt = 0;
            bus.avm_waitrequest = 1'b0;
            return;
        end
        if (pixel_valid) begin
            tx_armed = 1;
            tx_left  = tx_busy_polls;
        end
        if (bus.avm_read && bus.avm_write) both_err++;
        if (!(bus.avm_read || bus.avm_write)) begin
            stall_cnt = 0;
            bus.avm_waitrequest = 1'b0;
            bus.avm_readdata = $urandom;
            return;
        end
        req = {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata};
        if (stall_cnt == 0) held_req = req;
        else if (req !== held_req) stab_err++;
        if (stall_cnt < wait_cycles) begin
            stall_cnt++;
            bus.avm_waitrequest = 1'b1;
            bus.avm_readdata = $urandom | 32'hC0;
            return;
        end
        stall_cnt = 0;
        bus.avm_waitrequest = 1'b0;
        rd = $urandom;
        if (bus.avm_write) begin
            if (bus.avm_address != 5'd4) bad_addr_err++;
            log_q.push_back('{1'b1, bus.avm_address, bus.avm_writedata, cyc});
            tx_armed = 0;
        end else if (bus.avm_address == 5'd8) begin
            rx_rdy = (rx_q.size() > 0) && (rx_q[0].delay == 0);
            if (rx_q.size() > 0 && rx_q[0].delay > 0) begin
                h = rx_q[0];
                h.delay--;
                rx_q[0] = h;
            end
            tx_rdy = !(tx_armed && tx_left > 0);
            if (tx_armed && tx_left > 0) tx_left--;
            rd[7] = rx_rdy;
            rd[6] = tx_rdy;
            log_q.push_back('{1'b0, 5'd8, rd, cyc});
        end else if (bus.avm_address == 5'd0) begin
            if (rx_q.size() == 0 || rx_q[0].delay > 0) rx_early_err++;
            if (rx_q.size() > 0) begin
                h = rx_q.pop_front();
                rd[7:0] = h.data;
            end
            log_q.push_back('{1'b0, 5'd0, rd, cyc});
        end else begin
            bad_addr_err++;
        end
        bus.avm_readdata = rd;
    endtask

    initial begin
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = '0;
        forever begin
            @(negedge clk);
            respond();
        end
    end

    // Output monitor: calc_start pulses, held images, pixel strobes and store_finish rise.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sf_prev = 0;
            end else begin
                if (bus.calc_start) begin
                    cs_cnt++;
                    cs_cyc    = cyc;
                    cs_images = bus.calc_images;
                end
                if (wait_window && (bus.avm_read || bus.avm_write)) wait_bus_err++;
                if (wait_window && bus.calc_images !== cs_images) img_err++;
                if (pixel_valid) pix_log.push_back('{pixel_value, addr_store, cyc});
                if (store_finish && !sf_prev) sf_cyc = cyc;
                sf_prev = store_finish;
            end
        end
    end

    // One pixel: feed its bytes, answer calc_start, check the store strobe and TX echo.
    task automatic run_pixel(input img_t b, input int first, input int wc, input int fin_delay,
                             input int txp, input logic [7:0] res, input bit last, input string tag);
        logic [IMAGE_NUMBER*8-1:0] exp_img;
        int n0, p0, l0, t, fin_cyc, wi, n_stat, last_rx, pv_cyc;
        exp_img = '0;
        wait_cycles = wc;
        tx_busy_polls = txp;
        n0 = cs_cnt; p0 = pix_log.size(); l0 = log_q.size();
        for (int k = 0; k < IMAGE_NUMBER; k++) begin
            exp_img = exp_img | ({{((IMAGE_NUMBER-1)*8){1'b0}}, b[k]} << (8*k));
            if (k >= first) rx_q.push_back('{int'($urandom_range(0, 3)), b[k]});
        end
        t = 0;
        while (cs_cnt == n0 && t < 2000) begin tick(); t++; end
        n_checks++;
        if (cs_cnt == n0) begin
            n_fail++;
            $display("FAIL %s calc_start_timeout: no calc_start after %0d cycles, want one", tag, t);
            return;
        end
        n_checks++;
        if (cs_images !== exp_img) begin
            n_fail++;
            $display("FAIL %s calc_images: got %h want %h", tag, cs_images, exp_img);
        end
        last_rx = -100;
        for (int j = log_q.size() - 1; j >= 0; j--) begin
            if (!log_q[j].wr && log_q[j].addr == 5'd0) begin last_rx = log_q[j].cyc; break; end
        end
        n_checks++;
        if (cs_cyc != last_rx + 1) begin
            n_fail++;
            $display("FAIL %s calc_start_latency: got %0d want 1", tag, cs_cyc - last_rx);
        end
        wait_window = 1;
        repeat (fin_delay) tick();
        wait_window = 0;
        bus.calc_finish = 1'b1;
        bus.calc_result = res;
        fin_cyc = cyc;
        tick();
        bus.calc_finish = 1'b0;
        bus.calc_result = $urandom;
        tick();
        n_checks++;
        if (pix_log.size() != p0 + 1 || cs_cnt != n0 + 1) begin
            n_fail++;
            $display("FAIL %s pulse_counts: pixel_valid %0d calc_start %0d want 1 and 1",
                     tag, pix_log.size() - p0, cs_cnt - n0);
        end
        if (pix_log.size() <= p0) return;
        pv_cyc = pix_log[p0].cyc;
        n_checks++;
        if (pix_log[p0].v !== res || pix_log[p0].a !== ADDR_W'(exp_pix)) begin
            n_fail++;
            $display("FAIL %s pixel: got value %h addr %0d want value %h addr %0d",
                     tag, pix_log[p0].v, pix_log[p0].a, res, exp_pix);
        end
        n_checks++;
        if (pv_cyc != fin_cyc + 1) begin
            n_fail++;
            $display("FAIL %s pixel_latency: got %0d want 1", tag, pv_cyc - fin_cyc);
        end
        exp_pix++;
        t = 0; wi = -1;
        while (wi < 0 && t < 2000) begin
            for (int j = l0; j < log_q.size(); j++) begin
                if (log_q[j].wr) begin wi = j; break; end
            end
            if (wi < 0) begin tick(); t++; end
        end
        n_checks++;
        if (wi < 0) begin
            n_fail++;
            $display("FAIL %s tx_timeout: no TX write after %0d cycles, want one", tag, t);
            return;
        end
        n_checks++;
        if (log_q[wi].addr != 5'd4 || log_q[wi].data !== {24'h0, res}) begin
            n_fail++;
            $display("FAIL %s tx_write: got addr %0d data %h want addr 4 data %h",
                     tag, log_q[wi].addr, log_q[wi].data, {24'h0, res});
        end
        n_stat = 0;
        for (int j = l0; j < wi; j++) begin
            if (!log_q[j].wr && log_q[j].addr == 5'd8 && log_q[j].cyc >= pv_cyc) n_stat++;
        end
        n_checks++;
        if (n_stat != txp + 1) begin
            n_fail++;
            $display("FAIL %s tx_polls: got %0d want %0d", tag, n_stat, txp + 1);
        end
        if (!last) begin
            t = 0;
            while (log_q.size() <= wi + 1 && t < 100) begin tick(); t++; end
            n_checks++;
            if (log_q.size() <= wi + 1 || log_q[wi+1].wr || log_q[wi+1].addr != 5'd8) begin
                n_fail++;
                $display("FAIL %s back_to_rx: no STATUS read after TX write, want one", tag);
            end
        end
        n_checks++;
        if (stab_err + both_err + rx_early_err + bad_addr_err + wait_bus_err + img_err != 0) begin
            n_fail++;
            $display("FAIL %s bus_rules: stab %0d both %0d early %0d addr %0d waitbus %0d img %0d want all 0",
                     tag, stab_err, both_err, rx_early_err, bad_addr_err, wait_bus_err, img_err);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (bus.avm_read !== 1'b1 || bus.avm_address !== 5'd8 || bus.avm_write !== 1'b0 ||
            bus.avm_writedata !== 32'h0 || bus.calc_start !== 1'b0 || bus.calc_images !== '0) begin
            n_fail++;
            $display("FAIL %s bus_reset: got rd %b addr %0d wr %b wd %h cs %b img %h want 1 8 0 0 0 0",
                     tag, bus.avm_read, bus.avm_address, bus.avm_write, bus.avm_writedata,
                     bus.calc_start, bus.calc_images);
        end
        n_checks++;
        if (pixel_value !== 8'h0 || pixel_valid !== 1'b0 || addr_store !== '0 || store_finish !== 1'b0) begin
            n_fail++;
            $display("FAIL %s out_reset: got pv %h valid %b addr %0d sf %b want 0 0 0 0",
                     tag, pixel_value, pixel_valid, addr_store, store_finish);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_values("reset_async");
        tick(); tick();
        check_reset_values("reset_held");
        log_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_poll_rx();
        int t;
        bit ok;
        wait_cycles = 0;
        rx_q.push_back('{10, 8'h10});
        t = 0;
        while (log_q.size() < 12 && t < 200) begin tick(); t++; end
        n_checks++;
        if (log_q.size() < 12) begin
            n_fail++;
            $display("FAIL poll_rx_timeout: got %0d transfers want 12", log_q.size());
            return;
        end
        ok = 1;
        for (int j = 0; j < 11; j++) begin
            if (log_q[j].wr || log_q[j].addr != 5'd8 || log_q[j].data[7] != (j == 10)) ok = 0;
            if (j > 0 && log_q[j].cyc != log_q[j-1].cyc + 1) ok = 0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL poll_rx_status: got non back-to-back or wrong STATUS reads, want 11 consecutive");
        end
        n_checks++;
        if (log_q[11].wr || log_q[11].addr != 5'd0 || log_q[11].cyc != log_q[10].cyc + 1) begin
            n_fail++;
            $display("FAIL poll_rx_read: got wr %b addr %0d want read addr 0",
                     log_q[11].wr, log_q[11].addr);
        end
        n_checks++;
        if (cs_cnt != 0) begin
            n_fail++;
            $display("FAIL poll_rx_no_calc: got %0d calc_start want 0", cs_cnt);
        end
    endtask

    task automatic test_gather();
        img_t b;
        b[0] = 8'h10; b[1] = 8'h20; b[2] = 8'h30; b[3] = 8'h40;
        run_pixel(b, 1, 0, 7, 3, 8'h55, 0, "gather");
    endtask

    task automatic test_waitrequest();
        img_t b;
        for (int k = 0; k < IMAGE_NUMBER; k++) b[k] = 8'($urandom);
        run_pixel(b, 0, 5, int'($urandom_range(0, 10)), int'($urandom_range(0, 4)),
                  8'($urandom), 0, "waitreq");
    endtask

    task automatic test_back_to_back();
        img_t b;
        for (int k = 0; k < IMAGE_NUMBER; k++) b[k] = 8'($urandom);
        run_pixel(b, 0, 0, 0, 0, 8'($urandom), 0, "b2b_same_cycle");
        for (int k = 0; k < IMAGE_NUMBER; k++) b[k] = 8'($urandom);
        run_pixel(b, 0, int'($urandom_range(0, 2)), int'($urandom_range(1, 5)),
                  int'($urandom_range(0, 2)), 8'($urandom), 1, "b2b_last");
    endtask

    task automatic test_frame_end();
        int t, l0;
        t = 0;
        while (!store_finish && t < 50) begin tick(); t++; end
        n_checks++;
        if (store_finish !== 1'b1 || pix_log.size() != NPIX || sf_cyc <= pix_log[NPIX-1].cyc) begin
            n_fail++;
            $display("FAIL frame_done: got sf %b pixels %0d want sf 1 after pixel %0d",
                     store_finish, pix_log.size(), NPIX);
        end
        l0 = log_q.size();
        rx_q.push_back('{0, 8'hA1});
        rx_q.push_back('{0, 8'hA2});
        repeat (40) tick();
        n_checks++;
        if (log_q.size() != l0 || bus.avm_read !== 1'b0 || bus.avm_write !== 1'b0) begin
            n_fail++;
            $display("FAIL done_idle: got %0d new transfers rd %b wr %b want 0 0 0",
                     log_q.size() - l0, bus.avm_read, bus.avm_write);
        end
        n_checks++;
        if (store_finish !== 1'b1 || pix_log.size() != NPIX) begin
            n_fail++;
            $display("FAIL done_sticky: got sf %b pixels %0d want 1 %0d",
                     store_finish, pix_log.size(), NPIX);
        end
    endtask

    task automatic test_reset_mid_calc();
        img_t b;
        int t, n0, p0;
        rst_n = 1'b0;
        tick();
        rx_q.delete();
        tx_armed = 0;
        exp_pix = 0;
        rst_n = 1'b1;
        wait_cycles = 0;
        n0 = cs_cnt;
        for (int k = 0; k < IMAGE_NUMBER; k++) rx_q.push_back('{0, 8'($urandom)});
        t = 0;
        while (cs_cnt == n0 && t < 500) begin tick(); t++; end
        n_checks++;
        if (cs_cnt == n0) begin
            n_fail++;
            $display("FAIL rst_mid_calc_start: no calc_start after %0d cycles, want one", t);
        end
        tick();
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_mid_calc");
        p0 = pix_log.size();
        bus.calc_finish = 1'b1;
        bus.calc_result = 8'hAA;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        bus.calc_finish = 1'b0;
        tick();
        n_checks++;
        if (pix_log.size() != p0 || pixel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_calc_ignored: got %0d pixel_valid want 0", pix_log.size() - p0);
        end
        for (int k = 0; k < IMAGE_NUMBER; k++) b[k] = 8'($urandom);
        run_pixel(b, 0, 1, 3, 1, 8'($urandom), 0, "after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.calc_finish = 1'b0;
        bus.calc_result = 8'h0;
        test_reset();
        test_poll_rx();
        test_gather();
        test_waitrequest();
        test_back_to_back();
        test_frame_end();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
